// File: rtl/axilite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI-Lite read or
// write transaction out, one response back. Every output is a register.
module axilite_cmd_master #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  // command stream
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]  cmd_wstrb,
  // response stream
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [1:0]               rsp_resp,
  output logic                     rsp_write,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  // read address channel
  output logic [ADDR_WIDTH-1:0]    araddr,
  output logic                     arvalid,
  input  logic                     arready,
  // read data channel
  input  logic [DATA_WIDTH-1:0]    rdata,
  input  logic [1:0]               rresp,
  input  logic                     rvalid,
  output logic                     rready,
  // write address channel
  output logic [ADDR_WIDTH-1:0]    awaddr,
  output logic                     awvalid,
  input  logic                     awready,
  // write data channel
  output logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH/8-1:0]  wstrb,
  output logic                     wvalid,
  input  logic                     wready,
  // write response channel
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD_A = 3'd3,
    RD_R = 3'd4,
    RSP  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic                     cmd_ready_nxt;
  logic                     rsp_valid_nxt;
  logic [DATA_WIDTH-1:0]    rsp_rdata_nxt;
  logic [1:0]               rsp_resp_nxt;
  logic                     rsp_write_nxt;
  logic [ERR_CNT_WIDTH-1:0] err_count_nxt;
  logic [ADDR_WIDTH-1:0]    araddr_nxt;
  logic                     arvalid_nxt;
  logic                     rready_nxt;
  logic [ADDR_WIDTH-1:0]    awaddr_nxt;
  logic                     awvalid_nxt;
  logic [DATA_WIDTH-1:0]    wdata_nxt;
  logic [STRB_WIDTH-1:0]    wstrb_nxt;
  logic                     wvalid_nxt;
  logic                     bready_nxt;

  // SLVERR (2) and DECERR (3) both have bit 1 set; the count sticks at all-ones.
  function automatic logic [ERR_CNT_WIDTH-1:0] err_sat_inc(
    input logic [ERR_CNT_WIDTH-1:0] cnt,
    input logic [1:0]               resp
  );
    if (resp[1] && (cnt != {ERR_CNT_WIDTH{1'b1}}))
      return cnt + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    return cnt;
  endfunction

  always_comb begin
    state_nxt     = state;
    cmd_ready_nxt = cmd_ready;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    rsp_resp_nxt  = rsp_resp;
    rsp_write_nxt = rsp_write;
    err_count_nxt = err_count;
    araddr_nxt    = araddr;
    arvalid_nxt   = arvalid;
    rready_nxt    = rready;
    awaddr_nxt    = awaddr;
    awvalid_nxt   = awvalid;
    wdata_nxt     = wdata;
    wstrb_nxt     = wstrb;
    wvalid_nxt    = wvalid;
    bready_nxt    = bready;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_ready_nxt = 1'b0;
          if (cmd_write) begin
            awaddr_nxt  = cmd_addr;
            wdata_nxt   = cmd_wdata;
            wstrb_nxt   = cmd_wstrb;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            state_nxt   = WR;
          end else begin
            araddr_nxt  = cmd_addr;
            arvalid_nxt = 1'b1;
            state_nxt   = RD_A;
          end
        end
      end

      // AW and W retire independently; B is only opened once both are gone.
      WR: begin
        if (awvalid && awready) awvalid_nxt = 1'b0;
        if (wvalid && wready)   wvalid_nxt  = 1'b0;
        if (!awvalid_nxt && !wvalid_nxt) begin
          bready_nxt = 1'b1;
          state_nxt  = WR_B;
        end
      end

      WR_B: begin
        if (bvalid && bready) begin
          bready_nxt    = 1'b0;
          rsp_rdata_nxt = '0;
          rsp_resp_nxt  = bresp;
          rsp_write_nxt = 1'b1;
          rsp_valid_nxt = 1'b1;
          err_count_nxt = err_sat_inc(err_count, bresp);
          state_nxt     = RSP;
        end
      end

      RD_A: begin
        if (arvalid && arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_R;
        end
      end

      RD_R: begin
        if (rvalid && rready) begin
          rready_nxt    = 1'b0;
          rsp_rdata_nxt = rdata;
          rsp_resp_nxt  = rresp;
          rsp_write_nxt = 1'b0;
          rsp_valid_nxt = 1'b1;
          err_count_nxt = err_sat_inc(err_count, rresp);
          state_nxt     = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      rsp_write <= 1'b0;
      err_count <= '0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= cmd_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_resp  <= rsp_resp_nxt;
      rsp_write <= rsp_write_nxt;
      err_count <= err_count_nxt;
      araddr    <= araddr_nxt;
      arvalid   <= arvalid_nxt;
      rready    <= rready_nxt;
      awaddr    <= awaddr_nxt;
      awvalid   <= awvalid_nxt;
      wdata     <= wdata_nxt;
      wstrb     <= wstrb_nxt;
      wvalid    <= wvalid_nxt;
      bready    <= bready_nxt;
    end
  end

endmodule

// File: doc/axilite_cmd_master.md
Name: axilite_cmd_master

Overview:
- Single-outstanding AXI4-Lite master that turns a simple valid/ready command stream from the coprocessor sequencer into one AXI-Lite read or write transaction.
- Sits directly upstream of the AXI-Lite slave register cells and drives their read-address, read-data, write-address, write-data and write-response channels.
- Returns read data and response code on a valid/ready response stream.
- Keeps a saturating count of non-OKAY responses.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; must be a multiple of 8.
- ERR_CNT_WIDTH, 16, width of the error counter.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  AXI response code: 0 OKAY, 1 EXOKAY, 2 SLVERR, 3 DECERR.
- rsp_write  out  1  echoes cmd_write.
- err_count  out  ERR_CNT_WIDTH  saturating count of SLVERR/DECERR responses.
- araddr  out  ADDR_WIDTH
- arvalid  out  1
- arready  in  1
- rdata  in  DATA_WIDTH
- rresp  in  2
- rvalid  in  1
- rready  out  1
- awaddr  out  ADDR_WIDTH
- awvalid  out  1
- awready  in  1
- wdata  out  DATA_WIDTH
- wstrb  out  DATA_WIDTH/8
- wvalid  out  1
- wready  in  1
- bresp  in  2
- bvalid  in  1
- bready  out  1

Behaviour:
- Reset (areset=1 at a clock edge): state IDLE. All valid/ready outputs are 0 except cmd_ready=1. Address, data, strobe, rsp_rdata and rsp_resp registers are 0. rsp_write=0, err_count=0. Reset mid-transaction abandons it immediately; no response is produced.
- All AXI and response outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, WR, WR_B, RD_A, RD_R, RSP.
- IDLE:
  - cmd_ready=1.
  - On a write handshake: latch addr/wdata/wstrb, assert awvalid=1 and wvalid=1 next cycle, go to WR.
  - On a read handshake: latch addr, assert arvalid=1, go to RD_A.
  - cmd_ready drops the cycle after acceptance. Minimum issue latency is 1 cycle.
- WR:
  - AW and W complete independently. awvalid clears the cycle after awready is seen; wvalid clears the cycle after wready is seen.
  - Both may complete in the same cycle, or in either order.
  - A valid, once raised, holds with stable payload until its handshake.
  - When both are done, assert bready=1 and go to WR_B.
- WR_B: on bvalid & bready, capture bresp, set rsp_rdata=0, bready=0, go to RSP.
- RD_A: on arready, arvalid=0, rready=1, go to RD_R.
- RD_R: on rvalid, capture rdata/rresp, rready=0, go to RSP.
- RSP:
  - rsp_valid=1 and the response fields are held stable until rsp_ready.
  - On rsp_ready: rsp_valid=0, cmd_ready=1, go to IDLE.
  - The next command can be accepted on the cycle after the response handshake.
- err_count increments by 1 when a response with code 2 or 3 is captured. It saturates at all-ones; no wrap. EXOKAY does not count.
- No timeout. A slave that never responds stalls the block until reset.
- Only one transaction is outstanding at a time. AXI ID, cache and prot signals are not driven by this block.

Test Plan:
- Write OKAY: cmd write addr=0x10, wdata=0xDEADBEEF, wstrb=0xF; slave asserts awready and wready in the same cycle, bvalid 2 cycles later with bresp=0 -> awaddr=0x10 and wdata=0xDEADBEEF while valid; then rsp_valid with rsp_resp=0, rsp_write=1, rsp_rdata=0; err_count stays 0.
- Skewed write channels: wready 3 cycles before awready -> wvalid drops after its handshake, awvalid holds with stable awaddr; bready rises only after both handshakes; exactly one response.
- Read with backpressure: read addr=0x24; arready delayed 4 cycles; rdata=0x12345678, rresp=0; rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stay stable; cmd_ready=0 until the response handshake.
- Errors and saturation: ERR_CNT_WIDTH=2; four reads returning rresp=2, then one returning rresp=1 -> err_count goes 1, 2, 3, 3, 3; rsp_resp reports 2 four times, then 1.
- Reset mid-operation: assert areset while in WR_B with bvalid low -> next cycle all valids are 0, cmd_ready=1, err_count=0; a following read completes normally.
- Back-to-back: a write then a read with cmd_valid held high -> the second command is accepted the cycle after the first response handshake, never earlier.
